agc_gain_update: RTL

- Downstream consumer of the EMA level smoother in the AGC chain.
- Compares each smoothed level sample against a programmable target window.
- Steps a saturating gain word down fast on overload (attack) and up slowly on under-level (decay), with a settle blanking period after every gain change.
- The Gain output drives the AGC gain multiplier at the front of the chain.

---
 rtl/agc_gain_update.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/agc_gain_update.sv
// agc_gain_update
//   Gain update stage of the AGC loop. Each smoothed level sample from the
//   EMA stage is compared against a target window (target +/- hysteresis).
//   Overload steps the gain down at once (attack). A run of DECAY_HOLD
//   consecutive under-level samples steps it up (decay). After enable and
//   after every gain change, the next SETTLE samples are discarded.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   Enable        loop enable (level-sensitive)
//   Ema_Level     signed smoothed level, qualified by Ema_Valid
//   Target_Level  non-negative target level
//   Hysteresis    non-negative half-width of the dead band
//   Gain          unsigned Q2.16 gain word
//   Gain_Valid    one-cycle pulse when Gain takes a new value
//   Gain_At_Min   Gain == GAIN_MIN
//   Gain_At_Max   Gain == GAIN_MAX
//   Agc_State     0 = IDLE, 1 = TRACK, 2 = SETTLE
module agc_gain_update #(
  parameter int unsigned        LWIDTH      = 48,
  parameter int unsigned        GWIDTH      = 18,
  parameter logic [GWIDTH-1:0]  GAIN_INIT   = 18'h10000,
  parameter logic [GWIDTH-1:0]  GAIN_MIN    = 18'h00400,
  parameter logic [GWIDTH-1:0]  GAIN_MAX    = 18'h3FFFF,
  parameter logic [GWIDTH-1:0]  ATTACK_STEP = 18'h00800,
  parameter logic [GWIDTH-1:0]  DECAY_STEP  = 18'h00100,
  parameter int unsigned        DECAY_HOLD  = 4,
  parameter int unsigned        SETTLE      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Enable,
  input  logic signed [LWIDTH-1:0] Ema_Level,
  input  logic                     Ema_Valid,
  input  logic [LWIDTH-1:0]        Target_Level,
  input  logic [LWIDTH-1:0]        Hysteresis,
  output logic [GWIDTH-1:0]        Gain,
  output logic                     Gain_Valid,
  output logic                     Gain_At_Min,
  output logic                     Gain_At_Max,
  output logic [1:0]               Agc_State
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [LWIDTH:0] LVL_MAX  = {2'b00, {(LWIDTH-1){1'b1}}};
  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [3:0]      HOLD_C   = 4'(DECAY_HOLD);

  // Stage 1: threshold compare
  logic [LWIDTH:0]        hi_sum;
  logic [LWIDTH:0]        hi_thr;
  logic signed [LWIDTH:0] lo_diff;
  logic [LWIDTH:0]        lo_thr;
  logic [LWIDTH:0]        lvl;
  logic                   v1;
  logic                   above;
  logic                   below;

  always_comb begin
    hi_sum  = {1'b0, Target_Level} + {1'b0, Hysteresis};
    hi_thr  = (hi_sum > LVL_MAX) ? LVL_MAX : hi_sum;
    lo_diff = $signed({1'b0, Target_Level}) - $signed({1'b0, Hysteresis});
    lo_thr  = lo_diff[LWIDTH] ? '0 : $unsigned(lo_diff);
    lvl     = Ema_Level[LWIDTH-1] ? '0 : {1'b0, Ema_Level};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      above <= 1'b0;
      below <= 1'b0;
    end else begin
      v1    <= Ema_Valid;
      above <= (lvl > hi_thr);
      below <= (lvl < lo_thr);
    end
  end

  // Stage 2: gain state machine
  state_t             state, state_nxt;
  logic [GWIDTH-1:0]  gain, gain_nxt;
  logic [7:0]         settle_cnt, settle_nxt;
  logic [3:0]         low_cnt, low_nxt;
  logic               gv_nxt;

  logic signed [GWIDTH:0] dec_raw;
  logic [GWIDTH-1:0]      dec_gain;
  logic [GWIDTH:0]        inc_raw;
  logic [GWIDTH-1:0]      inc_gain;

  always_comb begin
    dec_raw  = $signed({1'b0, gain}) - $signed({1'b0, ATTACK_STEP});
    dec_gain = (dec_raw < $signed({1'b0, GAIN_MIN})) ? GAIN_MIN : dec_raw[GWIDTH-1:0];
    inc_raw  = {1'b0, gain} + {1'b0, DECAY_STEP};
    inc_gain = (inc_raw > {1'b0, GAIN_MAX}) ? GAIN_MAX : inc_raw[GWIDTH-1:0];
  end

  always_comb begin
    state_nxt  = state;
    gain_nxt   = gain;
    settle_nxt = settle_cnt;
    low_nxt    = low_cnt;
    gv_nxt     = 1'b0;
    if (!Enable) begin
      // disable wins over any sample in flight; gain is kept
      state_nxt  = ST_IDLE;
      settle_nxt = '0;
      low_nxt    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_C;
          low_nxt    = '0;
        end
        ST_SETTLE: begin
          if (v1) begin
            settle_nxt = settle_cnt - 8'd1;
            if (settle_cnt <= 8'd1) begin
              state_nxt = ST_TRACK;
            end
          end
        end
        ST_TRACK: begin
          if (v1) begin
            if (above) begin
              low_nxt = '0;
              if (dec_gain != gain) begin
                gain_nxt   = dec_gain;
                gv_nxt     = 1'b1;
                settle_nxt = SETTLE_C;
                state_nxt  = ST_SETTLE;
              end
            end else if (below) begin
              if (low_cnt >= HOLD_C - 4'd1) begin
                low_nxt = '0;
                if (inc_gain != gain) begin
                  gain_nxt   = inc_gain;
                  gv_nxt     = 1'b1;
                  settle_nxt = SETTLE_C;
                  state_nxt  = ST_SETTLE;
                end
              end else begin
                low_nxt = low_cnt + 4'd1;
              end
            end else begin
              low_nxt = '0;
            end
          end
        end
        default: begin
          state_nxt  = ST_IDLE;
          settle_nxt = '0;
          low_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      gain        <= GAIN_INIT;
      settle_cnt  <= '0;
      low_cnt     <= '0;
      Gain_Valid  <= 1'b0;
      Gain_At_Min <= (GAIN_INIT == GAIN_MIN);
      Gain_At_Max <= (GAIN_INIT == GAIN_MAX);
    end else begin
      state       <= state_nxt;
      gain        <= gain_nxt;
      settle_cnt  <= settle_nxt;
      low_cnt     <= low_nxt;
      Gain_Valid  <= gv_nxt;
      Gain_At_Min <= (gain_nxt == GAIN_MIN);
      Gain_At_Max <= (gain_nxt == GAIN_MAX);
    end
  end

  assign Gain      = gain;
  assign Agc_State = state;

endmodule
